// File: rtl/mem_arbiter_if.sv
// Bundle of the three buses that meet at the memory arbiter: the icache
// request port, the dcache request port and the main memory port.
// The arbiter takes the slave view; the caches and memory model take master.
interface mem_arbiter_if #(
  parameter int BLOCK_ADDR_W = 6,
  parameter int DATA_W       = 128
);
  // icache side
  logic                    i_read;
  logic [BLOCK_ADDR_W-1:0] i_address;
  logic [DATA_W-1:0]       i_readdata;
  logic                    i_busywait;
  // dcache side
  logic                    d_read;
  logic                    d_write;
  logic [BLOCK_ADDR_W-1:0] d_address;
  logic [DATA_W-1:0]       d_writedata;
  logic [DATA_W-1:0]       d_readdata;
  logic                    d_busywait;
  // memory side
  logic                    mem_read;
  logic                    mem_write;
  logic [BLOCK_ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0]       mem_writedata;
  logic [DATA_W-1:0]       mem_readdata;
  logic                    mem_busywait;

  modport slave (
    input  i_read, i_address,
    output i_readdata, i_busywait,
    input  d_read, d_write, d_address, d_writedata,
    output d_readdata, d_busywait,
    output mem_read, mem_write, mem_address, mem_writedata,
    input  mem_readdata, mem_busywait
  );

  modport master (
    output i_read, i_address,
    input  i_readdata, i_busywait,
    output d_read, d_write, d_address, d_writedata,
    input  d_readdata, d_busywait,
    input  mem_read, mem_write, mem_address, mem_writedata,
    output mem_readdata, mem_busywait
  );
endinterface

// File: rtl/mem_arbiter.sv
// Memory arbiter: shares the single block-wide main memory port between the
// instruction cache and the data cache. One block transfer at a time; when
// both caches request together the side that did not win last time is served.
module mem_arbiter #(
  parameter int BLOCK_ADDR_W = 6,
  parameter int DATA_W       = 128
) (
  input  logic         clock,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_t                  state_q, state_d;
  logic                    last_grant_q, last_grant_d;
  logic                    launched_q, launched_d;
  logic [BLOCK_ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic                    dwr_q, dwr_d;

  logic d_req;
  logic serving;
  logic complete;
  logic grant_i;
  logic grant_d;

  // A write-back request dominates a simultaneous read request.
  assign d_req   = bus.d_read | bus.d_write;
  assign serving = (state_q == SERVE_I) || (state_q == SERVE_D);
  // Memory only raises busywait one edge after seeing the strobe, so its
  // busywait is meaningless until the strobe has been launched.
  assign complete = serving && launched_q && !bus.mem_busywait;

  // Round-robin choice made in IDLE: icache wins unless dcache also asks and
  // icache was the last side served.
  assign grant_i = bus.i_read && (!d_req || (last_grant_q == GRANT_D));
  assign grant_d = d_req && !grant_i;

  // State and latched-request registers; reset aborts any transfer in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_D;
      launched_q   <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      dwr_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      launched_q   <= launched_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      dwr_q        <= dwr_d;
    end
  end

  // Next-state logic: grant from IDLE, wait for memory completion in SERVE_x.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    launched_d   = launched_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    dwr_d        = dwr_q;
    case (state_q)
      IDLE: begin
        launched_d = 1'b0;
        if (grant_i) begin
          state_d      = SERVE_I;
          addr_d       = bus.i_address;
          last_grant_d = GRANT_I;
        end else if (grant_d) begin
          state_d      = SERVE_D;
          addr_d       = bus.d_address;
          wdata_d      = bus.d_writedata;
          dwr_d        = bus.d_write;
          last_grant_d = GRANT_D;
        end
      end
      SERVE_I, SERVE_D: begin
        // Always return to IDLE after a transfer so there is a gap cycle.
        if (complete) begin
          state_d    = IDLE;
          launched_d = 1'b0;
        end else begin
          launched_d = 1'b1;
        end
      end
      default: begin
        state_d    = IDLE;
        launched_d = 1'b0;
      end
    endcase
  end

  // Memory strobes and per-cache responses, decoded straight from the state so
  // an asynchronous reset drops the strobes in the same cycle.
  always_comb begin
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.mem_address   = '0;
    bus.mem_writedata = '0;
    bus.i_readdata    = '0;
    bus.d_readdata    = '0;
    case (state_q)
      SERVE_I: begin
        bus.mem_read    = 1'b1;
        bus.mem_address = addr_q;
        if (complete) begin
          bus.i_readdata = bus.mem_readdata;
        end
      end
      SERVE_D: begin
        bus.mem_read      = !dwr_q;
        bus.mem_write     = dwr_q;
        bus.mem_address   = addr_q;
        bus.mem_writedata = wdata_q;
        if (complete && !dwr_q) begin
          bus.d_readdata = bus.mem_readdata;
        end
      end
      default: begin
      end
    endcase
    // A waiting request (granted or not) stalls until its completion cycle.
    bus.i_busywait = bus.i_read && !((state_q == SERVE_I) && complete);
    bus.d_busywait = d_req && !((state_q == SERVE_D) && complete);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: two cache request drivers, a latency-controlled
// memory model, and a scoreboard monitor that checks every grant and every
// completion against expectations queued by the directed test sequence.
module tb_mem_arbiter;

  typedef struct {
    logic         rd;
    logic         wr;
    logic [5:0]   addr;
    logic [127:0] data;
  } req_t;

  typedef struct {
    logic         wr;
    logic [5:0]   addr;
    logic [127:0] wdata;
  } grant_t;

  logic clock;
  logic reset;

  mem_arbiter_if #(.BLOCK_ADDR_W(6), .DATA_W(128)) bus ();

  mem_arbiter #(.BLOCK_ADDR_W(6), .DATA_W(128)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  req_t         i_q[$];
  req_t         d_q[$];
  grant_t       grant_q[$];
  logic [127:0] i_resp_q[$];
  logic [127:0] d_resp_q[$];

  logic i_active = 1'b0;
  logic d_active = 1'b0;
  logic i_timeout = 1'b0;
  logic d_timeout = 1'b0;

  int           mem_lat = 1;
  int           wr_count = 0;
  logic [5:0]   last_wr_addr = '0;
  logic [127:0] last_wr_data = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  // Memory contents seen by reads.
  function automatic logic [127:0] mem_func(input logic [5:0] a);
    if (a == 6'h2A) return 128'hDEADBEEF_01234567_89ABCDEF_DEADBEEF;
    if (a == 6'h01) return 128'h11111111_22222222_33333333_44444444;
    return {4{24'hC0FFEE, 2'b00, a}};
  endfunction

  // Memory model: busywait rises one edge after a strobe, stays high mem_lat
  // cycles, then data/commit appear with busywait low.
  int   cnt = 0;
  logic served = 1'b0;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.mem_busywait <= 1'b0;
      bus.mem_readdata <= '0;
      cnt              <= 0;
      served           <= 1'b0;
    end else if (bus.mem_busywait) begin
      if (cnt <= 1) begin
        bus.mem_busywait <= 1'b0;
        served           <= 1'b1;
        if (bus.mem_write) begin
          wr_count     <= wr_count + 1;
          last_wr_addr <= bus.mem_address;
          last_wr_data <= bus.mem_writedata;
        end else begin
          bus.mem_readdata <= mem_func(bus.mem_address);
        end
      end else begin
        cnt <= cnt - 1;
      end
    end else if (!(bus.mem_read || bus.mem_write)) begin
      served <= 1'b0;
    end else if (!served) begin
      bus.mem_busywait <= 1'b1;
      cnt              <= mem_lat;
    end
  end

  // icache driver: holds each request until its completion, back-to-back.
  initial begin
    req_t it;
    int   n;
    bus.i_read    = 1'b0;
    bus.i_address = '0;
    forever begin
      if (i_q.size() == 0) begin
        @(posedge clock);
        #1;
      end else begin
        it            = i_q.pop_front();
        i_active      = 1'b1;
        bus.i_read    = 1'b1;
        bus.i_address = it.addr;
        n = 0;
        do begin
          @(negedge clock);
          n++;
        end while (bus.i_busywait && n < 400);
        if (bus.i_busywait) i_timeout = 1'b1;
        @(posedge clock);
        #1;
        bus.i_read = 1'b0;
        i_active   = 1'b0;
      end
    end
  end

  // dcache driver: same handshake with read/write/data.
  initial begin
    req_t it;
    int   n;
    bus.d_read      = 1'b0;
    bus.d_write     = 1'b0;
    bus.d_address   = '0;
    bus.d_writedata = '0;
    forever begin
      if (d_q.size() == 0) begin
        @(posedge clock);
        #1;
      end else begin
        it              = d_q.pop_front();
        d_active        = 1'b1;
        bus.d_read      = it.rd;
        bus.d_write     = it.wr;
        bus.d_address   = it.addr;
        bus.d_writedata = it.data;
        n = 0;
        do begin
          @(negedge clock);
          n++;
        end while (bus.d_busywait && n < 400);
        if (bus.d_busywait) d_timeout = 1'b1;
        @(posedge clock);
        #1;
        bus.d_read  = 1'b0;
        bus.d_write = 1'b0;
        d_active    = 1'b0;
      end
    end
  end

  // Scoreboard monitor: checks each new grant and each completion.
  initial begin
    logic   strobe_prev;
    logic   strobe;
    grant_t g;
    logic [127:0] e;
    strobe_prev = 1'b0;
    forever begin
      @(negedge clock);
      strobe = bus.mem_read | bus.mem_write;
      if (!reset) begin
        if (strobe && !strobe_prev) begin
          if (grant_q.size() == 0) begin
            note_fail("unexpected_grant");
          end else begin
            g = grant_q.pop_front();
            check("grant_kind", 128'({bus.mem_write, bus.mem_read}), 128'({g.wr, ~g.wr}));
            check("grant_addr", 128'(bus.mem_address), 128'(g.addr));
            check("grant_wdata", bus.mem_writedata, g.wr ? g.wdata : 128'h0);
            $display("grant wr=%0d addr=%h", bus.mem_write, bus.mem_address);
          end
        end
        if (bus.i_read && !bus.i_busywait) begin
          if (i_resp_q.size() == 0) begin
            note_fail("unexpected_i_done");
          end else begin
            e = i_resp_q.pop_front();
            check("i_readdata", bus.i_readdata, e);
            $display("icache done data=%h", bus.i_readdata);
          end
        end else begin
          check("i_readdata_zero", bus.i_readdata, 128'h0);
        end
        if ((bus.d_read || bus.d_write) && !bus.d_busywait) begin
          if (d_resp_q.size() == 0) begin
            note_fail("unexpected_d_done");
          end else begin
            e = d_resp_q.pop_front();
            check("d_readdata", bus.d_readdata, e);
            $display("dcache done data=%h", bus.d_readdata);
          end
        end else begin
          check("d_readdata_zero", bus.d_readdata, 128'h0);
        end
      end
      strobe_prev = strobe;
    end
  end

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while ((i_q.size() != 0 || d_q.size() != 0 || i_active || d_active) && n < budget);
    if (i_q.size() != 0 || d_q.size() != 0 || i_active || d_active) note_fail("idle_timeout");
    @(negedge clock);
  endtask

  function automatic req_t mk_req(input logic rd, input logic wr, input logic [5:0] a,
                                  input logic [127:0] d);
    req_t r;
    r.rd = rd; r.wr = wr; r.addr = a; r.data = d;
    return r;
  endfunction

  function automatic grant_t mk_grant(input logic wr, input logic [5:0] a, input logic [127:0] d);
    grant_t g;
    g.wr = wr; g.addr = a; g.wdata = d;
    return g;
  endfunction

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int wc0;
    reset = 1'b1;

    // Test A: reset with i_read held, then a lone icache read of 2A, latency 5.
    mem_lat = 5;
    i_q.push_back(mk_req(1'b1, 1'b0, 6'h2A, 128'h0));
    grant_q.push_back(mk_grant(1'b0, 6'h2A, 128'h0));
    i_resp_q.push_back(128'hDEADBEEF_01234567_89ABCDEF_DEADBEEF);
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_i_busywait", 128'(bus.i_busywait), 128'h1);
    check("rst_d_busywait", 128'(bus.d_busywait), 128'h0);
    check("rst_mem_read", 128'(bus.mem_read), 128'h0);
    check("rst_mem_write", 128'(bus.mem_write), 128'h0);
    check("rst_mem_address", 128'(bus.mem_address), 128'h0);
    check("rst_mem_writedata", bus.mem_writedata, 128'h0);
    check("rst_i_readdata", bus.i_readdata, 128'h0);
    reset = 1'b0;
    @(negedge clock);
    check("a_cycle1_mem_read", 128'(bus.mem_read), 128'h1);
    check("a_cycle1_mem_address", 128'(bus.mem_address), 128'h2A);
    n = 1;
    do begin
      @(negedge clock);
      n++;
    end while (bus.i_busywait && n < 60);
    check("a_completion_cycle", 128'(n), 128'd7);
    @(negedge clock);
    check("a_idle_after", 128'({bus.mem_read, bus.mem_write}), 128'h0);
    wait_idle(100);

    // Test B: simultaneous i_read 01 and d_write 10 after reset; icache first.
    reset   = 1'b1;
    mem_lat = 3;
    i_q.push_back(mk_req(1'b1, 1'b0, 6'h01, 128'h0));
    d_q.push_back(mk_req(1'b0, 1'b1, 6'h10, {16{8'h5A}}));
    grant_q.push_back(mk_grant(1'b0, 6'h01, 128'h0));
    grant_q.push_back(mk_grant(1'b1, 6'h10, {16{8'h5A}}));
    i_resp_q.push_back(128'h11111111_22222222_33333333_44444444);
    d_resp_q.push_back(128'h0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    n = 0;
    do begin
      @(negedge clock);
      n++;
      check("b_d_busy_during_i", 128'(bus.d_busywait), 128'h1);
    end while (bus.i_busywait && n < 60);
    @(negedge clock);
    check("b_gap_no_strobe", 128'({bus.mem_read, bus.mem_write}), 128'h0);
    check("b_gap_d_busy", 128'(bus.d_busywait), 128'h1);
    @(negedge clock);
    check("b_d_write_strobe", 128'(bus.mem_write), 128'h1);
    wait_idle(100);

    // Test C: both requesters continuously busy for 6 transfers.
    mem_lat = 2;
    i_q.push_back(mk_req(1'b1, 1'b0, 6'h02, 128'h0));
    i_q.push_back(mk_req(1'b1, 1'b0, 6'h04, 128'h0));
    i_q.push_back(mk_req(1'b1, 1'b0, 6'h06, 128'h0));
    d_q.push_back(mk_req(1'b1, 1'b0, 6'h03, 128'h0));
    d_q.push_back(mk_req(1'b1, 1'b0, 6'h05, 128'h0));
    d_q.push_back(mk_req(1'b1, 1'b0, 6'h07, 128'h0));
    grant_q.push_back(mk_grant(1'b0, 6'h02, 128'h0));
    grant_q.push_back(mk_grant(1'b0, 6'h03, 128'h0));
    grant_q.push_back(mk_grant(1'b0, 6'h04, 128'h0));
    grant_q.push_back(mk_grant(1'b0, 6'h05, 128'h0));
    grant_q.push_back(mk_grant(1'b0, 6'h06, 128'h0));
    grant_q.push_back(mk_grant(1'b0, 6'h07, 128'h0));
    i_resp_q.push_back(128'hC0FFEE02_C0FFEE02_C0FFEE02_C0FFEE02);
    i_resp_q.push_back(128'hC0FFEE04_C0FFEE04_C0FFEE04_C0FFEE04);
    i_resp_q.push_back(128'hC0FFEE06_C0FFEE06_C0FFEE06_C0FFEE06);
    d_resp_q.push_back(128'hC0FFEE03_C0FFEE03_C0FFEE03_C0FFEE03);
    d_resp_q.push_back(128'hC0FFEE05_C0FFEE05_C0FFEE05_C0FFEE05);
    d_resp_q.push_back(128'hC0FFEE07_C0FFEE07_C0FFEE07_C0FFEE07);
    wait_idle(400);

    // Test D: d_read and d_write together at 3F; the write wins.
    mem_lat = 2;
    wc0 = wr_count;
    d_q.push_back(mk_req(1'b1, 1'b1, 6'h3F, 128'h01234567_89ABCDEF_FEDCBA98_76543210));
    grant_q.push_back(mk_grant(1'b1, 6'h3F, 128'h01234567_89ABCDEF_FEDCBA98_76543210));
    d_resp_q.push_back(128'h0);
    wait_idle(100);
    check("d_write_count", 128'(wr_count - wc0), 128'd1);
    check("d_write_addr", 128'(last_wr_addr), 128'h3F);
    check("d_write_data", last_wr_data, 128'h01234567_89ABCDEF_FEDCBA98_76543210);

    // Test E: reset two cycles into SERVE_D, write re-arbitrated afterwards.
    mem_lat = 8;
    wc0 = wr_count;
    d_q.push_back(mk_req(1'b0, 1'b1, 6'h15, 128'hCAFEF00D_00000000_FFFFFFFF_12345678));
    grant_q.push_back(mk_grant(1'b1, 6'h15, 128'hCAFEF00D_00000000_FFFFFFFF_12345678));
    grant_q.push_back(mk_grant(1'b1, 6'h15, 128'hCAFEF00D_00000000_FFFFFFFF_12345678));
    d_resp_q.push_back(128'h0);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!bus.mem_write && n < 20);
    if (!bus.mem_write) note_fail("e_wait_write");
    @(negedge clock);
    check("e_cycle2_mem_write", 128'(bus.mem_write), 128'h1);
    #1;
    reset = 1'b1;
    #1;
    check("e_abort_strobes", 128'({bus.mem_read, bus.mem_write}), 128'h0);
    check("e_abort_d_busy", 128'(bus.d_busywait), 128'h1);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    wait_idle(100);
    check("e_write_once", 128'(wr_count - wc0), 128'd1);
    check("e_write_addr", 128'(last_wr_addr), 128'h15);

    // Everything queued must have been consumed.
    check("grant_q_empty", 128'(grant_q.size()), 128'h0);
    check("i_resp_q_empty", 128'(i_resp_q.size()), 128'h0);
    check("d_resp_q_empty", 128'(d_resp_q.size()), 128'h0);
    check("driver_timeouts", 128'({i_timeout, d_timeout}), 128'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
